// File: rtl/waveform_playback_ctrl.sv
// Playback sequencer that owns the waveform BRAM read port. Time-shares the
// port between host pipe transfers and rate-divided sample playback.
module waveform_playback_ctrl #(
   parameter int ADDR_W = 11,
   parameter int DIV_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [ADDR_W-1:0] length,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic              host_req,
   input  logic              host_done,
   output logic              host_grant,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       sample_out,
   output logic              sample_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pass_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HOST   = 3'd1,
      RUN    = 3'd2,
      DRAIN1 = 3'd3,
      DRAIN2 = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] last_addr;
   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_nxt;
   logic [DIV_W-1:0]  rate_lat;
   logic              loop_lat;
   logic [CNT_W-1:0]  pass_nxt;
   logic              tick;
   logic              latch_cfg;
   logic              rd_pend;

   // Host handshake: host_req is a level request; host_grant is held while the
   // host owns the port and drops the cycle after host_done or host_req falls.
   // A request is only granted from IDLE, so a running playback finishes first.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      div_nxt   = div_cnt;
      pass_nxt  = pass_count;
      latch_cfg = 1'b0;
      tick      = 1'b0;
      case (state)
         IDLE: begin
            if (host_req) begin
               state_nxt = HOST;
            end else if (start && !stop) begin
               state_nxt = RUN;
               latch_cfg = 1'b1;
               addr_nxt  = '0;
               div_nxt   = '0;
               pass_nxt  = '0;
            end
         end
         HOST: begin
            if (host_done || !host_req) state_nxt = IDLE;
         end
         RUN: begin
            if (stop) begin
               state_nxt = DRAIN1;
            end else begin
               tick    = (div_cnt == rate_lat);
               div_nxt = tick ? '0 : div_cnt + 1'b1;
               if (tick) begin
                  if (addr == last_addr) begin
                     if (pass_count != '1) pass_nxt = pass_count + 1'b1;
                     if (loop_lat) addr_nxt = '0;
                     else          state_nxt = DRAIN1;
                  end else begin
                     addr_nxt = addr + 1'b1;
                  end
               end
            end
         end
         DRAIN1:  state_nxt = DRAIN2;
         DRAIN2:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Read data lands one cycle after the read; rd_pend carries the read across
   // that cycle so sample_out registers it on the following edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr         <= '0;
         div_cnt      <= '0;
         rate_lat     <= '0;
         last_addr    <= '0;
         loop_lat     <= 1'b0;
         pass_count   <= '0;
         rd_pend      <= 1'b0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         addr       <= addr_nxt;
         div_cnt    <= div_nxt;
         pass_count <= pass_nxt;
         if (latch_cfg) begin
            rate_lat  <= rate_div;
            last_addr <= length - 1'b1;
            loop_lat  <= loop_mode;
         end
         rd_pend      <= tick;
         sample_valid <= rd_pend;
         if (rd_pend) sample_out <= ram_rdata;
         done <= (state == DRAIN2);
      end
   end

   assign ram_rd_en  = tick;
   assign ram_addr   = addr;
   assign busy       = (state != IDLE);
   assign host_grant = (state == HOST);

endmodule

// File: tb/tb_waveform_playback_ctrl.sv
// Bench for waveform_playback_ctrl: directed and randomized playback runs
// checked against a cycle-level reference model of reads, samples and done.
module tb_waveform_playback_ctrl;

   localparam int ADDR_W = 4;
   localparam int DIV_W  = 16;
   localparam int CNT_W  = 2;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int PC_MAX = (1 << CNT_W) - 1;

   logic              clk       = 1'b0;
   logic              reset     = 1'b0;
   logic              start     = 1'b0;
   logic              stop      = 1'b0;
   logic              loop_mode = 1'b0;
   logic [ADDR_W-1:0] length    = '0;
   logic [DIV_W-1:0]  rate_div  = '0;
   logic              host_req  = 1'b0;
   logic              host_done = 1'b0;
   logic [31:0]       ram_rdata = '0;
   logic              host_grant;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       sample_out;
   logic              sample_valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  pass_count;

   logic [31:0] mem [DEPTH];
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_hold = '0;

   typedef struct {
      int                c;
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic              sv;
      logic [31:0]       so;
      logic              dn;
      logic              bsy;
      logic              gnt;
   } trace_t;

   trace_t      tr_q[$];
   logic [63:0] exp_rd_q[$];
   logic [63:0] exp_sv_q[$];

   waveform_playback_ctrl #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .loop_mode    (loop_mode),
      .length       (length),
      .rate_div     (rate_div),
      .host_req     (host_req),
      .host_done    (host_done),
      .host_grant   (host_grant),
      .ram_rd_en    (ram_rd_en),
      .ram_addr     (ram_addr),
      .ram_rdata    (ram_rdata),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done),
      .pass_count   (pass_count)
   );

   // clock / cycle counter / one-cycle-latency BRAM
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

   always @(negedge clk) begin : monitor
      trace_t t;
      t.c   = cyc;
      t.rd  = ram_rd_en;
      t.addr = ram_addr;
      t.sv  = sample_valid;
      t.so  = sample_out;
      t.dn  = done;
      t.bsy = busy;
      t.gnt = host_grant;
      tr_q.push_back(t);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      total++;
      if ({sample_out, pass_count, ram_addr, ram_rd_en, sample_valid, done, host_grant, busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got so=%h pc=%0d addr=%0d rd=%b sv=%b done=%b gnt=%b busy=%b want all 0",
                  sample_out, pass_count, ram_addr, ram_rd_en, sample_valid, done, host_grant, busy);
      end
      reset = 1'b1;
      step();
      total++;
      if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got busy=%b rd=%b want 0 0", busy, ram_rd_en);
      end
   endtask

   // Drives one playback run and checks it against the reference model.
   // stop_dly / host_dly: cycles after the start cycle to pulse stop / raise host_req, -1 = never.
   task automatic test_playback(input string tag, input int len, input int rate, input bit lp,
                                input int stop_dly, input int host_dly);
      int          t0, n, stop_at, host_at, nat_end, exp_done, end_cyc, nrd, exp_pass, rc;
      int          done_cnt, done_at, j, c, lim;
      logic        g, b;
      logic [31:0] hold;
      logic [63:0] obs_rd_q[$];
      logic [63:0] obs_sv_q[$];

      foreach (mem[i]) mem[i] = $urandom;
      n       = (len == 0) ? DEPTH : len;
      t0      = cyc;
      stop_at = (stop_dly < 0) ? -1 : t0 + stop_dly;
      host_at = (host_dly < 0) ? -1 : t0 + host_dly;

      // reference model: the k-th read (k>=1) lands at t0 + k*(rate+1) on address (k-1) mod n
      exp_rd_q.delete();
      exp_sv_q.delete();
      nrd     = 0;
      nat_end = t0 + (rate + 1) * n;
      forever begin
         rc = t0 + (rate + 1) * (nrd + 1);
         if (!lp && nrd == n) break;
         if (stop_at >= 0 && rc >= stop_at) break;
         if (nrd >= 4096) break;
         exp_rd_q.push_back({32'(rc), 32'(nrd % n)});
         exp_sv_q.push_back({32'(rc + 2), mem[nrd % n]});
         nrd++;
      end
      exp_pass = nrd / n;
      if (exp_pass > PC_MAX) exp_pass = PC_MAX;
      exp_done = (stop_at >= 0 && (lp || stop_at <= nat_end)) ? stop_at + 3 : nat_end + 3;
      end_cyc  = exp_done + 4;

      length    = ADDR_W'(len);
      rate_div  = DIV_W'(rate);
      loop_mode = lp;
      start     = 1'b1;
      tr_q.delete();
      step();
      start     = 1'b0;
      length    = ADDR_W'($urandom);
      rate_div  = DIV_W'($urandom);
      loop_mode = 1'($urandom);
      while (cyc < end_cyc) begin
         stop = (cyc == stop_at);
         if (cyc == host_at) host_req = 1'b1;
         step();
      end
      stop = 1'b0;

      done_cnt = 0;
      done_at  = -1;
      foreach (tr_q[i]) begin
         if (tr_q[i].rd) obs_rd_q.push_back({32'(tr_q[i].c), 32'(tr_q[i].addr)});
         if (tr_q[i].sv) obs_sv_q.push_back({32'(tr_q[i].c), tr_q[i].so});
         if (tr_q[i].dn) begin
            if (done_cnt == 0) done_at = tr_q[i].c;
            done_cnt++;
         end
      end

      total++;
      if (obs_rd_q.size() != exp_rd_q.size()) begin
         bad++;
         $display("FAIL %s read_count got=%0d want=%0d", tag, obs_rd_q.size(), exp_rd_q.size());
      end
      lim = (obs_rd_q.size() < exp_rd_q.size()) ? obs_rd_q.size() : exp_rd_q.size();
      for (int i = 0; i < lim; i++) begin
         total++;
         if (obs_rd_q[i] !== exp_rd_q[i]) begin
            bad++;
            $display("FAIL %s read%0d got cyc=t0+%0d addr=%0d want cyc=t0+%0d addr=%0d", tag, i,
                     int'(obs_rd_q[i][63:32]) - t0, obs_rd_q[i][31:0], int'(exp_rd_q[i][63:32]) - t0, exp_rd_q[i][31:0]);
         end
      end

      total++;
      if (obs_sv_q.size() != exp_sv_q.size()) begin
         bad++;
         $display("FAIL %s sample_count got=%0d want=%0d", tag, obs_sv_q.size(), exp_sv_q.size());
      end
      lim = (obs_sv_q.size() < exp_sv_q.size()) ? obs_sv_q.size() : exp_sv_q.size();
      for (int i = 0; i < lim; i++) begin
         total++;
         if (obs_sv_q[i] !== exp_sv_q[i]) begin
            bad++;
            $display("FAIL %s sample%0d got cyc=t0+%0d data=%h want cyc=t0+%0d data=%h", tag, i,
                     int'(obs_sv_q[i][63:32]) - t0, obs_sv_q[i][31:0], int'(exp_sv_q[i][63:32]) - t0, exp_sv_q[i][31:0]);
         end
      end

      total++;
      if (done_cnt != 1 || done_at != exp_done) begin
         bad++;
         $display("FAIL %s done got count=%0d first=t0+%0d want count=1 at t0+%0d", tag, done_cnt, done_at - t0, exp_done - t0);
      end

      total++;
      if (pass_count !== CNT_W'(exp_pass)) begin
         bad++;
         $display("FAIL %s pass_count got=%0d want=%0d", tag, pass_count, exp_pass);
      end

      // per-cycle: held sample value, busy and grant
      hold = exp_hold;
      j    = 0;
      foreach (tr_q[i]) begin
         c = tr_q[i].c;
         if (j < exp_sv_q.size() && int'(exp_sv_q[j][63:32]) == c) begin
            hold = exp_sv_q[j][31:0];
            j++;
         end
         g = (host_at >= 0) && (c > ((exp_done > host_at) ? exp_done : host_at));
         b = (c > t0 && c < exp_done) || g;
         total++;
         if (tr_q[i].so !== hold || tr_q[i].bsy !== b || tr_q[i].gnt !== g) begin
            bad++;
            $display("FAIL %s cycle t0+%0d got so=%h busy=%b gnt=%b want so=%h busy=%b gnt=%b",
                     tag, c - t0, tr_q[i].so, tr_q[i].bsy, tr_q[i].gnt, hold, b, g);
         end
      end
      exp_hold = hold;

      host_req = 1'b0;
      step();
      step();
   endtask

   task automatic test_arbitration();
      host_req = 1'b1;
      start    = 1'b1;
      step();
      start    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (host_grant !== 1'b1 || busy !== 1'b1 || ram_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL arb_host%0d got gnt=%b busy=%b rd=%b want 1 1 0", i, host_grant, busy, ram_rd_en);
         end
         start = (i == 1);
         step();
      end
      start     = 1'b0;
      host_done = 1'b1;
      host_req  = 1'b0;
      step();
      host_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (host_grant !== 1'b0 || busy !== 1'b0 || ram_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL arb_after_done%0d got gnt=%b busy=%b rd=%b want 0 0 0", i, host_grant, busy, ram_rd_en);
         end
         step();
      end
      host_req = 1'b1;
      step();
      total++;
      if (host_grant !== 1'b1) begin
         bad++;
         $display("FAIL arb_regrant got=%b want=1", host_grant);
      end
      host_req = 1'b0;
      step();
      total++;
      if (host_grant !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL arb_req_drop got gnt=%b busy=%b want 0 0", host_grant, busy);
      end
   endtask

   task automatic test_start_stop();
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL start_stop%0d got busy=%b rd=%b want 0 0", i, busy, ram_rd_en);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_run();
      int n_sv;
      int n_rd;
      foreach (mem[i]) mem[i] = $urandom | 32'h1;
      length    = '0;
      rate_div  = '0;
      loop_mode = 1'b0;
      start     = 1'b1;
      step();
      start     = 1'b0;
      repeat (5) step();
      total++;
      if (ram_addr !== ADDR_W'(5) || ram_rd_en !== 1'b1) begin
         bad++;
         $display("FAIL mid_run_addr got addr=%0d rd=%b want 5 1", ram_addr, ram_rd_en);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({sample_out, pass_count, ram_addr, ram_rd_en, sample_valid, done, host_grant, busy} !== '0) begin
         bad++;
         $display("FAIL mid_run_reset got so=%h pc=%0d addr=%0d rd=%b sv=%b done=%b gnt=%b busy=%b want all 0",
                  sample_out, pass_count, ram_addr, ram_rd_en, sample_valid, done, host_grant, busy);
      end
      step();
      reset = 1'b1;
      tr_q.delete();
      repeat (6) step();
      n_sv = 0;
      n_rd = 0;
      foreach (tr_q[i]) begin
         if (tr_q[i].sv) n_sv++;
         if (tr_q[i].rd || tr_q[i].bsy || tr_q[i].dn) n_rd++;
      end
      total++;
      if (n_sv != 0 || n_rd != 0) begin
         bad++;
         $display("FAIL post_reset_quiet got sample_valids=%0d active_cycles=%0d want 0 0", n_sv, n_rd);
      end
      exp_hold = '0;
      test_playback("after_reset", 6, 1, 1'b0, -1, -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         int len, rate, n, sd, hd;
         bit lp;
         len  = $urandom_range(0, DEPTH - 1);
         rate = $urandom_range(0, 3);
         lp   = 1'($urandom_range(0, 1));
         n    = (len == 0) ? DEPTH : len;
         if (lp) sd = $urandom_range(1, 60);
         else    sd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (rate + 1) * n + 4)) : -1;
         hd   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
         test_playback("random", len, rate, lp, sd, hd);
      end
   endtask

   initial begin
      test_reset();
      test_playback("one_shot", 4, 0, 1'b0, -1, -1);
      test_playback("rate_div", 2, 3, 1'b0, -1, -1);
      test_playback("loop", 3, 0, 1'b1, 11, -1);
      test_playback("saturate", 1, 0, 1'b1, 7, -1);
      test_playback("length_zero", 0, 0, 1'b0, -1, -1);
      test_playback("stop_one_shot", 8, 1, 1'b0, 5, -1);
      test_arbitration();
      test_playback("host_during_run", 4, 1, 1'b0, -1, 2);
      test_start_stop();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
